// File: rtl/color_sense_sequencer_pkg.sv
// Shared types and constants for the TCS3200 colour-sense sequencer:
// FSM states, filter-select encodings, colour codes and the count width.
package color_pkg;

    localparam int FREQ_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_NEXT,
        ST_CLASSIFY
    } state_t;

    typedef enum logic [1:0] {
        CH_RED,
        CH_GREEN,
        CH_BLUE
    } chan_t;

    // {S2,S3} filter select values for the TCS3200.
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    localparam logic [1:0] COLOR_NONE  = 2'd0;
    localparam logic [1:0] COLOR_RED   = 2'd1;
    localparam logic [1:0] COLOR_GREEN = 2'd2;
    localparam logic [1:0] COLOR_BLUE  = 2'd3;

endpackage

// File: rtl/color_sense_sequencer_classifier.sv
// Combinational winner-take-all over the three channel counts; ties go to
// the earlier channel (red, then green, then blue), dim scenes report none.
module color_classifier
    import color_pkg::*;
(
    input  logic [FREQ_W-1:0] red,
    input  logic [FREQ_W-1:0] green,
    input  logic [FREQ_W-1:0] blue,
    input  logic [FREQ_W-1:0] min_count,
    output logic [1:0]        color
);

    logic [1:0]        win_code;
    logic [FREQ_W-1:0] win_val;

    always_comb begin
        win_code = COLOR_RED;
        win_val  = red;
        // Strict greater-than keeps the earlier channel on a tie.
        if (green > win_val) begin
            win_code = COLOR_GREEN;
            win_val  = green;
        end
        if (blue > win_val) begin
            win_code = COLOR_BLUE;
            win_val  = blue;
        end
        color = (win_val < min_count) ? COLOR_NONE : win_code;
    end

endmodule

// File: rtl/color_sense_sequencer.sv
// Steps the TCS3200 through red/green/blue, runs one frequency-counter window
// per channel after a settle delay, latches the counts and classifies them.
module color_sense_sequencer
    import color_pkg::*;
#(
    parameter int unsigned        SETTLE_CYCLES  = 100_000,
    parameter int unsigned        TIMEOUT_CYCLES = 8_000_000,
    parameter logic [FREQ_W-1:0]  MIN_COUNT      = 10'd20
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Measure,
    input  logic [FREQ_W-1:0] Freq,
    input  logic              Finished,
    output logic              Start,
    output logic              S2,
    output logic              S3,
    output logic [FREQ_W-1:0] RedFreq,
    output logic [FREQ_W-1:0] GreenFreq,
    output logic [FREQ_W-1:0] BlueFreq,
    output logic [1:0]        Color,
    output logic              ColorValid,
    output logic              Busy,
    output logic              Timeout
);

    localparam int SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LOAD  = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES);

    state_t                state, state_next;
    chan_t                 ch, ch_next;
    logic [SETTLE_W-1:0]   settle_cnt, settle_next;
    logic [TIMEOUT_W-1:0]  tmo_cnt, tmo_next;
    logic                  first_cycle, first_next;
    logic [1:0]            filt, filt_next;
    logic [FREQ_W-1:0]     red_next, green_next, blue_next;
    logic [1:0]            color_next, class_color;
    logic                  valid_next, timeout_next, start_next, busy_next;

    color_classifier u_classifier (
        .red       (RedFreq),
        .green     (GreenFreq),
        .blue      (BlueFreq),
        .min_count (MIN_COUNT),
        .color     (class_color)
    );

    assign S2 = filt[1];
    assign S3 = filt[0];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            ch          <= CH_RED;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            first_cycle <= 1'b0;
            filt        <= 2'b00;
            RedFreq     <= '0;
            GreenFreq   <= '0;
            BlueFreq    <= '0;
            Color       <= COLOR_NONE;
            ColorValid  <= 1'b0;
            Timeout     <= 1'b0;
            Start       <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_next;
            ch          <= ch_next;
            settle_cnt  <= settle_next;
            tmo_cnt     <= tmo_next;
            first_cycle <= first_next;
            filt        <= filt_next;
            RedFreq     <= red_next;
            GreenFreq   <= green_next;
            BlueFreq    <= blue_next;
            Color       <= color_next;
            ColorValid  <= valid_next;
            Timeout     <= timeout_next;
            Start       <= start_next;
            Busy        <= busy_next;
        end
    end

    always_comb begin
        state_next   = state;
        ch_next      = ch;
        settle_next  = settle_cnt;
        tmo_next     = tmo_cnt;
        first_next   = 1'b0;
        filt_next    = filt;
        red_next     = RedFreq;
        green_next   = GreenFreq;
        blue_next    = BlueFreq;
        color_next   = Color;
        valid_next   = 1'b0;
        timeout_next = Timeout;

        case (state)
            ST_IDLE: begin
                if (Measure) begin
                    ch_next      = CH_RED;
                    filt_next    = FILT_RED;
                    timeout_next = 1'b0;
                    settle_next  = SETTLE_LOAD;
                    state_next   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    tmo_next   = TIMEOUT_LOAD;
                    first_next = 1'b1;
                    state_next = ST_COUNT;
                end else begin
                    settle_next = settle_cnt - SETTLE_W'(1);
                end
            end
            ST_COUNT: begin
                // A Finished seen on the first COUNT cycle is left over from
                // the previous window; the counter only clears it after Start rises.
                if (Finished && !first_cycle) begin
                    case (ch)
                        CH_RED:   red_next   = Freq;
                        CH_GREEN: green_next = Freq;
                        default:  blue_next  = Freq;
                    endcase
                    state_next = ST_NEXT;
                end else if (tmo_cnt <= TIMEOUT_W'(1)) begin
                    case (ch)
                        CH_RED:   red_next   = '0;
                        CH_GREEN: green_next = '0;
                        default:  blue_next  = '0;
                    endcase
                    timeout_next = 1'b1;
                    state_next   = ST_NEXT;
                end else begin
                    tmo_next = tmo_cnt - TIMEOUT_W'(1);
                end
            end
            ST_NEXT: begin
                case (ch)
                    CH_RED: begin
                        ch_next     = CH_GREEN;
                        filt_next   = FILT_GREEN;
                        settle_next = SETTLE_LOAD;
                        state_next  = ST_SETTLE;
                    end
                    CH_GREEN: begin
                        ch_next     = CH_BLUE;
                        filt_next   = FILT_BLUE;
                        settle_next = SETTLE_LOAD;
                        state_next  = ST_SETTLE;
                    end
                    default: begin
                        // All three counts are registered by now.
                        color_next = class_color;
                        valid_next = 1'b1;
                        state_next = ST_CLASSIFY;
                    end
                endcase
            end
            ST_CLASSIFY: begin
                filt_next  = FILT_CLEAR;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        start_next = (state_next == ST_COUNT);
        busy_next  = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_color_sense_sequencer.sv
// Self-checking bench: a frequency-counter model feeds preset counts per
// filter, a scoreboard queue holds the expected {Color,R,G,B} per Measure.
module tb_color_sense_sequencer;
    import color_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       Measure = 1'b0;
    logic [9:0] Freq = '0;
    logic       Finished = 1'b0;
    logic       Start, S2, S3, ColorValid, Busy, Timeout;
    logic [9:0] RedFreq, GreenFreq, BlueFreq;
    logic [1:0] Color;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    // Counter model settings
    logic [9:0] r_cnt = '0, g_cnt = '0, b_cnt = '0;
    bit         withhold_green = 1'b0;
    int         mcnt = 0;

    // Observations from the last run
    int         obs_latency, obs_pulses, obs_rises, obs_glen, obs_seq_len;
    logic [7:0] obs_seq;
    bit         obs_busy_drop, obs_busy_after, obs_tmo_at_cv, obs_tmo_first, obs_rem_done;

    color_sense_sequencer #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (60),
        .MIN_COUNT      (10'd20)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Measure    (Measure),
        .Freq       (Freq),
        .Finished   (Finished),
        .Start      (Start),
        .S2         (S2),
        .S3         (S3),
        .RedFreq    (RedFreq),
        .GreenFreq  (GreenFreq),
        .BlueFreq   (BlueFreq),
        .Color      (Color),
        .ColorValid (ColorValid),
        .Busy       (Busy),
        .Timeout    (Timeout)
    );

    always #5 CLK = ~CLK;

    // Counter model: Finished rises 30 cycles after Start rises, cleared while Start is low.
    always @(negedge CLK) begin
        case ({S2, S3})
            2'b00:   Freq = r_cnt;
            2'b11:   Freq = g_cnt;
            2'b01:   Freq = b_cnt;
            default: Freq = '0;
        endcase
        if (Start !== 1'b1) begin
            mcnt = 0;
            Finished = 1'b0;
        end else begin
            mcnt++;
            if (mcnt >= 30 && !(withhold_green && {S2, S3} == 2'b11))
                Finished = 1'b1;
        end
    end

    task automatic run_measure(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                               input logic [1:0] exp_color, input logic [9:0] exp_g,
                               input bit wgreen, input bit remeasure);
        int n;
        logic [1:0] f, last_f;
        logic prev_start;
        logic [31:0] exp_v, got_v;
        r_cnt = r; g_cnt = g; b_cnt = b;
        withhold_green = wgreen;
        obs_latency = 0; obs_pulses = 0; obs_rises = 0; obs_glen = 0;
        obs_seq = '0; obs_seq_len = 0; obs_busy_drop = 0; obs_tmo_at_cv = 0;
        obs_tmo_first = 0; obs_rem_done = 0;
        last_f = 2'b00; prev_start = 1'b0;
        exp_q.push_back({exp_color, r, exp_g, b});
        @(negedge CLK);
        Measure = 1'b1;
        n = 0;
        while (n < 400 && (obs_latency == 0 || n < obs_latency + 10)) begin
            @(negedge CLK);
            n++;
            Measure = 1'b0;
            f = {S2, S3};
            if (n == 1) obs_tmo_first = Timeout;
            if (n == 1 || f != last_f) begin
                obs_seq = {obs_seq[5:0], f};
                obs_seq_len++;
            end
            last_f = f;
            if (Start && !prev_start) obs_rises++;
            prev_start = Start;
            if (Start && f == 2'b11) obs_glen++;
            if (obs_latency == 0 && !Busy) obs_busy_drop = 1'b1;
            if (remeasure && !obs_rem_done && Start && f == 2'b01) begin
                Measure = 1'b1;
                obs_rem_done = 1'b1;
            end
            if (ColorValid) begin
                obs_pulses++;
                if (obs_latency == 0) obs_latency = n;
                obs_tmo_at_cv = Timeout;
                got_v = {Color, RedFreq, GreenFreq, BlueFreq};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_unexpected got=%h required=none", got_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v) begin
                        failures++;
                        $display("FAIL scoreboard {color,r,g,b} got=%h required=%h", got_v, exp_v);
                    end
                end
            end
        end
        obs_busy_after = Busy;
        checks++;
        if (obs_latency == 0) begin
            failures++;
            $display("FAIL colorvalid_timeout got=none required=pulse within 400 cycles");
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++; if (Start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b required=0", Start); end
        checks++; if ({S2, S3} !== 2'b00) begin failures++; $display("FAIL reset_filter got=%b required=00", {S2, S3}); end
        checks++; if (Busy !== 1'b0 || ColorValid !== 1'b0 || Timeout !== 1'b0) begin
            failures++; $display("FAIL reset_flags got=%b%b%b required=000", Busy, ColorValid, Timeout); end
        checks++; if ({Color, RedFreq, GreenFreq, BlueFreq} !== 32'h0) begin
            failures++; $display("FAIL reset_data got=%h required=0", {Color, RedFreq, GreenFreq, BlueFreq}); end
        Reset = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_red();
        run_measure(10'd200, 10'd50, 10'd40, COLOR_RED, 10'd50, 1'b0, 1'b0);
        checks++; if (obs_latency != 109) begin failures++; $display("FAIL red_latency got=%0d required=109", obs_latency); end
        checks++; if (obs_pulses != 1) begin failures++; $display("FAIL red_pulses got=%0d required=1", obs_pulses); end
        checks++; if (obs_seq_len != 4 || obs_seq !== 8'b00_11_01_10) begin
            failures++; $display("FAIL red_filter_seq got=%0d:%b required=4:00110110", obs_seq_len, obs_seq); end
        checks++; if (obs_rises != 3) begin failures++; $display("FAIL red_start_rises got=%0d required=3", obs_rises); end
        checks++; if (obs_busy_drop || obs_busy_after) begin
            failures++; $display("FAIL red_busy got=drop%0d/after%0d required=0/0", obs_busy_drop, obs_busy_after); end
    endtask

    task automatic test_tie();
        run_measure(10'd100, 10'd100, 10'd100, COLOR_RED, 10'd100, 1'b0, 1'b0);
        checks++; if (obs_pulses != 1) begin failures++; $display("FAIL tie3_pulses got=%0d required=1", obs_pulses); end
        run_measure(10'd10, 10'd150, 10'd150, COLOR_GREEN, 10'd150, 1'b0, 1'b0);
        checks++; if (obs_pulses != 1) begin failures++; $display("FAIL tie_gb_pulses got=%0d required=1", obs_pulses); end
    endtask

    task automatic test_dark();
        run_measure(10'd15, 10'd12, 10'd19, COLOR_NONE, 10'd12, 1'b0, 1'b0);
        checks++; if (obs_pulses != 1) begin failures++; $display("FAIL dark_pulses got=%0d required=1", obs_pulses); end
        checks++; if (obs_tmo_at_cv !== 1'b0) begin failures++; $display("FAIL dark_timeout got=%b required=0", obs_tmo_at_cv); end
    endtask

    task automatic test_timeout();
        run_measure(10'd80, 10'd90, 10'd100, COLOR_BLUE, 10'd0, 1'b1, 1'b0);
        checks++; if (obs_glen != 60) begin failures++; $display("FAIL tmo_green_len got=%0d required=60", obs_glen); end
        checks++; if (obs_tmo_at_cv !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%b required=1", obs_tmo_at_cv); end
        checks++; if (obs_latency != 139) begin failures++; $display("FAIL tmo_latency got=%0d required=139", obs_latency); end
        run_measure(10'd30, 10'd25, 10'd300, COLOR_BLUE, 10'd25, 1'b0, 1'b0);
        checks++; if (obs_tmo_first !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b required=0", obs_tmo_first); end
    endtask

    task automatic test_back_to_back();
        run_measure(10'd40, 10'd300, 10'd60, COLOR_GREEN, 10'd300, 1'b0, 1'b1);
        checks++; if (!obs_rem_done) begin failures++; $display("FAIL b2b_remeasure_driven got=0 required=1"); end
        checks++; if (obs_pulses != 1) begin failures++; $display("FAIL b2b_pulses got=%0d required=1", obs_pulses); end
        checks++; if (obs_busy_drop || obs_busy_after) begin
            failures++; $display("FAIL b2b_busy got=drop%0d/after%0d required=0/0", obs_busy_drop, obs_busy_after); end
        checks++; if (obs_latency != 109) begin failures++; $display("FAIL b2b_latency got=%0d required=109", obs_latency); end
    endtask

    task automatic test_reset_mid_settle();
        int n;
        r_cnt = 10'd222; g_cnt = 10'd33; b_cnt = 10'd44; withhold_green = 1'b0;
        @(negedge CLK);
        Measure = 1'b1;
        @(negedge CLK);
        Measure = 1'b0;
        n = 0;
        while (n < 200 && !({S2, S3} == 2'b11 && !Start)) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 200) begin failures++; $display("FAIL rst_reach_green_settle got=none required=green settle"); end
        @(negedge CLK);
        #2 Reset = 1'b1;
        #1;
        checks++; if (Start !== 1'b0 || Busy !== 1'b0) begin
            failures++; $display("FAIL rst_async_ctrl got=%b%b required=00", Start, Busy); end
        checks++; if ({S2, S3} !== 2'b00) begin failures++; $display("FAIL rst_async_filter got=%b required=00", {S2, S3}); end
        checks++; if ({RedFreq, GreenFreq, BlueFreq} !== 30'h0) begin
            failures++; $display("FAIL rst_async_counts got=%h required=0", {RedFreq, GreenFreq, BlueFreq}); end
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        run_measure(10'd500, 10'd20, 10'd21, COLOR_RED, 10'd20, 1'b0, 1'b0);
        checks++; if (obs_latency != 109) begin failures++; $display("FAIL rst_rerun_latency got=%0d required=109", obs_latency); end
    endtask

    initial begin
        test_reset();
        test_red();
        test_tie();
        test_dark();
        test_timeout();
        test_back_to_back();
        test_reset_mid_settle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/color_sense_sequencer.md
Name: color_sense_sequencer

Overview:
- Sits directly downstream of the frequency counter and upstream of the sort/decision logic.
- Steps the TCS3200 photodiode filter through red, green and blue, with a settle time after each filter change.
- For each channel: runs one counter window, latches the 10-bit count, then classifies the three counts into one colour code with a one-cycle valid strobe.

Parameters:
- SETTLE_CYCLES, 100_000: CLK cycles to hold Start low after each filter change, before counting.
- TIMEOUT_CYCLES, 8_000_000: maximum CLK cycles to wait for Finished per channel; must exceed the counter window of 6_250_000.
- MIN_COUNT, 10'd20: minimum winning count; below this the result is "none".

Ports:
- CLK, input, 1: system clock.
- Reset, input, 1: asynchronous, active-high reset.
- Measure, input, 1: one-cycle request to run a full R/G/B measurement. Ignored while Busy.
- Freq, input, 10: count from the frequency counter.
- Finished, input, 1: counter-done flag from the frequency counter.
- Start, output, 1: run/clear control to the frequency counter.
- S2, output, 1: TCS3200 filter select, high bit.
- S3, output, 1: TCS3200 filter select, low bit.
- RedFreq, output, 10: latched red count.
- GreenFreq, output, 10: latched green count.
- BlueFreq, output, 10: latched blue count.
- Color, output, 2: result code. 0 = none, 1 = red, 2 = green, 3 = blue.
- ColorValid, output, 1: one-cycle strobe when Color and the three counts are updated.
- Busy, output, 1: high from the cycle after Measure is accepted until the cycle ColorValid is driven.
- Timeout, output, 1: sticky flag; set when a channel times out, cleared on the next accepted Measure.

Behaviour:
- Reset (asynchronous, any state), all outputs registered:
  - State returns to IDLE.
  - Start=0, S2=0, S3=0, Busy=0, ColorValid=0, Timeout=0, Color=0, all count registers 0.
- Filter encoding (S2,S3): red = 00, green = 11, blue = 01, clear = 10. In IDLE the filter is parked on clear.
- States:
  - IDLE: on Measure=1, set ch=RED, drive the red filter, clear Timeout, load the settle counter, go to SETTLE.
  - SETTLE: Start=0. Count SETTLE_CYCLES cycles, then go to COUNT and load the timeout counter.
  - COUNT: Start=1.
    - On Finished=1, register Freq into the channel's count register and go to NEXT.
    - If the timeout counter expires first, store 0 for that channel, set Timeout, go to NEXT.
  - NEXT: Start=0 for this cycle, which is required so the counter clears Finished.
    - ch RED -> GREEN, GREEN -> BLUE: drive the new filter and go to SETTLE.
    - ch BLUE: go to CLASSIFY.
  - CLASSIFY: compute the winner and drive ColorValid=1 with Color for exactly one cycle. Park the filter on clear and go to IDLE.
- Latency: Measure to ColorValid = 3*(1 + SETTLE_CYCLES + T_count + 1) + 1 cycles, where T_count is the cycles spent in COUNT until Finished.
- Classification:
  - Winner is the strictly largest count. Ties resolve red > green > blue.
  - If the winning count < MIN_COUNT, Color = 0.
  - Comparisons are unsigned 10-bit; no arithmetic overflow is possible.
- Finished already high on entry to COUNT (stale): accepted only on the second or later COUNT cycle, because the counter clears Finished one cycle after Start rises.
- Measure while Busy: dropped, with no queueing. Measure in the same cycle as the CLASSIFY strobe is also dropped.
- Count registers and Color hold their values between measurements. Only ColorValid pulses.
- Reset mid-measurement: abort immediately and drop Start low. Partially captured counts are cleared to 0.
- Counter widths:
  - Settle counter: $clog2(SETTLE_CYCLES+1) bits.
  - Timeout counter: $clog2(TIMEOUT_CYCLES+1) bits.
  - Both count down to 0, with no wrap-around.

Decomposition:
- Shared package color_pkg holds:
  - the state enum;
  - filter-select constants FILT_RED, FILT_GREEN, FILT_BLUE, FILT_CLEAR;
  - colour codes COLOR_NONE, COLOR_RED, COLOR_GREEN, COLOR_BLUE;
  - the frequency width FREQ_W = 10.
- One sub-module: color_classifier, purely combinational. Takes the three counts plus MIN_COUNT and returns the colour code.
- The sequencer FSM and its counters stay in the top module.

Test Plan (SETTLE_CYCLES=4, TIMEOUT_CYCLES=60, MIN_COUNT=20; bench counter model asserts Finished 30 cycles after Start rises and returns preset counts):
- Red case: counts R=200, G=50, B=40, pulse Measure.
  - S2/S3 sequence is 00 -> 11 -> 01 -> 10.
  - Start goes low for ≥1 cycle between channels.
  - ColorValid is a single pulse with Color=1, RedFreq=200.
- Tie: R=G=B=100 -> Color=1. Then R=10, G=150, B=150 -> Color=2.
- Dark scene: R=15, G=12, B=19 -> Color=0, ColorValid still pulses, Timeout=0.
- Model withholds Finished on green:
  - The green COUNT state exits after 60 cycles.
  - GreenFreq=0, Timeout=1, blue is still measured, ColorValid pulses.
  - The next Measure clears Timeout.
- Measure is pulsed again during blue COUNT: ignored, exactly one ColorValid is produced, Busy stays high throughout.
- Reset asserted asynchronously in the middle of SETTLE:
  - Start, Busy, S2, S3 and the counts are 0 within the same cycle.
  - A subsequent Measure completes a normal run.
